// File: rtl/bp_burst_to_lite_pkg.sv
// Shared BedRock header layout, message encodings and converter state for the Burst-to-Lite path.
// Pure types and a sizing helper; no logic, no latency.
package bp_burst_to_lite_pkg;

  localparam int paddr_width_p   = 40;
  localparam int payload_width_p = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [3:0]                 msg_type;
    logic [3:0]                 subop;
    logic [paddr_width_p-1:0]   addr;
    logic [2:0]                 size;
    logic [payload_width_p-1:0] payload;
  } bp_bedrock_hdr_t;

  localparam int hdr_width_lp = $bits(bp_bedrock_hdr_t);

  typedef enum logic [1:0] {
    e_ready,
    e_data,
    e_send
  } bp_burst_to_lite_state_e;

  // Clamped to the buffer depth so an oversize request can never wrap the beat counter.
  function automatic int beats_for_size(input logic [2:0] size, input int beat_bytes, input int max_beats);
    int n;
    n = (1 << size) / beat_bytes;
    if (n < 1) n = 1;
    if (n > max_beats) n = max_beats;
    return n;
  endfunction

endpackage

// File: rtl/bp_burst_to_lite_if.sv
// Burst input channels (header + beats) and the wide Lite output channel of the converter.
// slave is the converter side, master is the producer/consumer side.
interface bp_burst_to_lite_if
  import bp_burst_to_lite_pkg::*;
#(
  parameter int in_data_width_p  = 64,
  parameter int out_data_width_p = 512
);

  localparam int out_msg_width_lp = hdr_width_lp + out_data_width_p;

  bp_bedrock_hdr_t              in_msg_header_i;
  logic                         in_msg_header_v_i;
  logic                         in_msg_header_ready_and_o;
  logic                         in_msg_has_data_i;
  logic [in_data_width_p-1:0]   in_msg_data_i;
  logic                         in_msg_data_v_i;
  logic                         in_msg_data_ready_and_o;
  logic                         in_msg_last_i;
  logic [out_msg_width_lp-1:0]  out_msg_o;
  logic                         out_msg_v_o;
  logic                         out_msg_ready_and_i;

  modport slave (
    input  in_msg_header_i, in_msg_header_v_i, in_msg_has_data_i,
    input  in_msg_data_i, in_msg_data_v_i, in_msg_last_i, out_msg_ready_and_i,
    output in_msg_header_ready_and_o, in_msg_data_ready_and_o, out_msg_o, out_msg_v_o
  );

  modport master (
    output in_msg_header_i, in_msg_header_v_i, in_msg_has_data_i,
    output in_msg_data_i, in_msg_data_v_i, in_msg_last_i, out_msg_ready_and_i,
    input  in_msg_header_ready_and_o, in_msg_data_ready_and_o, out_msg_o, out_msg_v_o
  );

endinterface

// File: rtl/bp_me_burst_sipo.sv
// Beat buffer: writes beats at a running index, clears on a new header, replicates the valid prefix to full width.
// Write takes effect on the next edge; output is a pure decode of the stored beats and the registered size.
module bp_me_burst_sipo
  import bp_burst_to_lite_pkg::*;
#(
  parameter int in_data_width_p  = 64,
  parameter int out_data_width_p = 512
)(
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        clear_i,
  input  logic                        v_i,
  input  logic [in_data_width_p-1:0]  data_i,
  input  logic [2:0]                  size_i,
  output logic                        last_o,
  output logic [out_data_width_p-1:0] data_o
);

  localparam int max_beats_lp = out_data_width_p / in_data_width_p;
  localparam int cnt_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

  logic [cnt_width_lp-1:0]                      cnt_r;
  logic [max_beats_lp-1:0][in_data_width_p-1:0] data_r;
  logic [out_data_width_p-1:0]                  flat;
  logic [7:0][out_data_width_p-1:0]             rep;

  assign last_o = (cnt_r == cnt_width_lp'(beats_for_size(size_i, in_data_width_p/8, max_beats_lp) - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r  <= '0;
      data_r <= '0;
    end else if (clear_i) begin
      cnt_r  <= '0;
      data_r <= '0;
    end else if (v_i) begin
      data_r[cnt_r] <= data_i;
      if (!last_o) cnt_r <= cnt_r + 1'b1;
    end
  end

  assign flat = data_r;

  // Each size repeats its first 2^size bytes; sizes at or above the full width pass straight through.
  for (genvar s = 0; s < 8; s++) begin : g_size
    localparam int fill_lp = ((8 << s) < out_data_width_p) ? (8 << s) : out_data_width_p;
    for (genvar i = 0; i < out_data_width_p; i++) begin : g_bit
      assign rep[s][i] = flat[i % fill_lp];
    end
  end

  assign data_o = rep[size_i];

endmodule

// File: rtl/bp_burst_to_lite.sv
// Collects one Burst header plus its beats and emits a single wide Lite message {header, data}.
// Output valid the cycle after the last beat (or header if no data); holds the message until accepted.
module bp_burst_to_lite
  import bp_burst_to_lite_pkg::*;
#(
  parameter int          in_data_width_p  = 64,
  parameter int          out_data_width_p = 512,
  parameter logic [15:0] payload_mask_p   = '0
)(
  input  logic              clk_i,
  input  logic              reset_n_i,
  bp_burst_to_lite_if.slave bus
);

  if (out_data_width_p % in_data_width_p != 0) begin : g_width_check
    $error("out_data_width_p must be a multiple of in_data_width_p");
  end

  bp_burst_to_lite_state_e     state_r, state_n;
  bp_bedrock_hdr_t             hdr_r;
  logic                        live_r;
  logic                        hdr_rdy, beat_rdy, out_v;
  logic                        hdr_hs, beat_hs, out_hs;
  logic                        has_data, last_beat;
  logic [out_data_width_p-1:0] data;

  // live_r keeps header ready low while reset is asserted even though the state sits in e_ready.
  assign hdr_rdy  = live_r & (state_r == e_ready);
  assign beat_rdy = (state_r == e_data);
  assign out_v    = (state_r == e_send);

  assign hdr_hs   = bus.in_msg_header_v_i & hdr_rdy;
  assign beat_hs  = bus.in_msg_data_v_i & beat_rdy;
  assign out_hs   = bus.out_msg_ready_and_i & out_v;
  assign has_data = payload_mask_p[bus.in_msg_header_i.msg_type];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      hdr_r   <= '0;
      live_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      live_r  <= 1'b1;
      if (hdr_hs) hdr_r <= bus.in_msg_header_i;
    end
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_ready: if (hdr_hs) state_n = has_data ? e_data : e_send;
      e_data:  if (beat_hs && last_beat) state_n = e_send;
      e_send:  if (out_hs) state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  bp_me_burst_sipo #(
    .in_data_width_p (in_data_width_p),
    .out_data_width_p(out_data_width_p)
  ) sipo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (hdr_hs),
    .v_i      (beat_hs),
    .data_i   (bus.in_msg_data_i),
    .size_i   (hdr_r.size),
    .last_o   (last_beat),
    .data_o   (data)
  );

  assign bus.in_msg_header_ready_and_o = hdr_rdy;
  assign bus.in_msg_data_ready_and_o   = beat_rdy;
  assign bus.out_msg_v_o               = out_v;
  assign bus.out_msg_o                 = {hdr_r, data};

  a_last_on_final_beat: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    beat_hs |-> (bus.in_msg_last_i == last_beat));

  a_has_data_matches_mask: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    hdr_hs |-> (bus.in_msg_has_data_i == has_data));

endmodule
